// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage.
// Imported by the fetch buffer and the fetch unit.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    ERR
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic is_misaligned(
    input logic [XLEN-1:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_buf.sv
// Two-entry output slot plus skid buffer.
// Push, pop and flush, with fill state exposed to the FSM.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         slot_valid_o,
  output fetch_entry_t slot_o,
  output logic         skid_valid_o
);

  logic         slot_valid_q, slot_valid_d;
  logic         skid_valid_q, skid_valid_d;
  fetch_entry_t slot_q, slot_d;
  fetch_entry_t skid_q, skid_d;
  logic         pop;

  assign pop = pop_i & slot_valid_q;

  always_comb begin
    slot_valid_d = slot_valid_q;
    skid_valid_d = skid_valid_q;
    slot_d       = slot_q;
    skid_d       = skid_q;
    if (flush_i) begin
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        slot_d       = skid_q;
        skid_valid_d = push_i;
        if (push_i) begin
          skid_d = push_entry_i;
        end
      end else if (push_i) begin
        slot_d = push_entry_i;
      end else begin
        slot_valid_d = 1'b0;
      end
    end else if (push_i) begin
      // Slot occupied and held: the word parks in the skid.
      if (!slot_valid_q) begin
        slot_valid_d = 1'b1;
        slot_d       = push_entry_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = push_entry_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      slot_q       <= '{instr: NOP_INSTR, pc: RESET_PC};
      skid_q       <= '{instr: NOP_INSTR, pc: RESET_PC};
    end else begin
      slot_valid_q <= slot_valid_d;
      skid_valid_q <= skid_valid_d;
      slot_q       <= slot_d;
      skid_q       <= skid_d;
    end
  end

  assign slot_valid_o = slot_valid_q;
  assign slot_o       = slot_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the pc, talks req/ack to imem,
// buffers words for the datapath and handles redirects.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] kill_addr_q;
  logic            kill_q;
  logic            misaligned_q;

  logic            slot_valid;
  logic            skid_valid;
  fetch_entry_t    slot;
  fetch_entry_t    push_entry;

  logic            redir_take;
  logic            redir_bad;
  logic            consume;
  logic            can_accept;
  logic            word_ok;

  assign imem_req  = (state_q == REQ) ||
                     (state_q == ERR && kill_q);
  // A killed request keeps its address until its ack.
  assign imem_addr = kill_q ? kill_addr_q : fetch_pc_q;

  assign redir_take = redirect && (state_q != ERR);
  assign redir_bad  = redir_take && is_misaligned(redirect_pc);
  assign consume    = slot_valid && !stall;
  assign can_accept = !slot_valid || consume;
  assign word_ok    = (state_q == REQ) && imem_ack &&
                      !kill_q && !redir_take;

  assign push_entry = '{instr: imem_rdata, pc: fetch_pc_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      kill_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      if (imem_req && imem_ack) begin
        kill_q <= 1'b0;
      end
      if (redir_take) begin
        fetch_pc_q <= redirect_pc;
        if (imem_req && !imem_ack) begin
          kill_q      <= 1'b1;
          kill_addr_q <= imem_addr;
        end
        if (redir_bad) begin
          state_q      <= ERR;
          misaligned_q <= 1'b1;
        end else begin
          state_q <= REQ;
        end
      end else begin
        unique case (state_q)
          IDLE: state_q <= REQ;
          REQ: begin
            if (word_ok) begin
              fetch_pc_q <= fetch_pc_q + XLEN'(4);
              if (!can_accept) begin
                state_q <= HOLD;
              end
            end
          end
          HOLD: begin
            if (consume || !skid_valid) begin
              state_q <= REQ;
            end
          end
          ERR: state_q <= ERR;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  fetch_buf #(
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk_i        (clk),
    .rst_ni       (reset),
    .push_i       (word_ok),
    .push_entry_i (push_entry),
    .pop_i        (consume),
    .flush_i      (redir_take),
    .slot_valid_o (slot_valid),
    .slot_o       (slot),
    .skid_valid_o (skid_valid)
  );

  assign instr_valid = slot_valid;
  assign instr       = slot_valid ? slot.instr : NOP_INSTR;
  assign pc          = slot.pc;
  assign pc_plus4    = slot.pc + XLEN'(4);
  assign misaligned  = misaligned_q;

endmodule
